// File: rtl/chop_gen_mc.sv
// Multi-channel chopper generator: shared period counter, per-channel polarity inversion at a
// programmable count, post-transition data-hold flag and matched output delay lines.
module chop_gen_mc #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned HOLD_W    = 8,
  parameter int unsigned CHOP_DLAY = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chop_en,
  input  logic              sync_i,
  input  logic [N_CH-1:0]   chop_default,
  input  logic [CNT_W-1:0]  change_count,
  input  logic [CNT_W-1:0]  max_count,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [N_CH-1:0]   chop_o,
  output logic [N_CH-1:0]   chop_dly_o,
  output logic              data_hold_o,
  output logic              period_start_o,
  output logic              cfg_err_o
);

  typedef enum logic [1:0] {StIdle, StRun, StErr} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  change_s_q, change_s_d;
  logic [CNT_W-1:0]  max_s_q, max_s_d;
  logic [N_CH-1:0]   default_s_q, default_s_d;
  logic [HOLD_W-1:0] hold_s_q, hold_s_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_CH-1:0]   chop_pipe_q [CHOP_DLAY];
  logic [CHOP_DLAY-1:0] hold_pipe_q;

  logic cfg_ok;
  logic wrap;
  logic hold;

  // Validity is judged on the live inputs, since they are what the shadows capture on this edge.
  assign cfg_ok = (max_count >= CNT_W'(2)) && (change_count != '0) &&
                  (change_count < max_count);
  assign wrap   = (cnt_q == max_s_q - CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    change_s_d  = change_s_q;
    max_s_d     = max_s_q;
    default_s_d = default_s_q;
    hold_s_d    = hold_s_q;
    hold_cnt_d  = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d      = '0;
        hold_cnt_d = '0;
        if (chop_en) begin
          change_s_d  = change_count;
          max_s_d     = max_count;
          default_s_d = chop_default;
          hold_s_d    = hold_len;
          if (cfg_ok) begin
            state_d    = StRun;
            hold_cnt_d = hold_len;
          end else begin
            state_d = StErr;
          end
        end
      end
      StRun: begin
        if (!chop_en) begin
          state_d    = StIdle;
          cnt_d      = '0;
          hold_cnt_d = '0;
        end else if (wrap || sync_i) begin
          cnt_d       = '0;
          change_s_d  = change_count;
          max_s_d     = max_count;
          default_s_d = chop_default;
          hold_s_d    = hold_len;
          if (cfg_ok) begin
            hold_cnt_d = hold_len;
          end else begin
            state_d    = StErr;
            hold_cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == change_s_q) begin
            hold_cnt_d = hold_s_q;
          end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end
      end
      StErr: begin
        cnt_d      = '0;
        hold_cnt_d = '0;
        if (!chop_en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    chop_o = chop_default;
    unique case (state_q)
      StRun:   chop_o = (cnt_q < change_s_q) ? default_s_q : ~default_s_q;
      StErr:   chop_o = default_s_q;
      default: chop_o = chop_default;
    endcase
  end

  assign hold           = (state_q == StRun) && (hold_cnt_q != '0);
  assign period_start_o = (state_q == StRun) && (cnt_q == '0);
  assign cfg_err_o      = (state_q == StErr);
  assign chop_dly_o     = chop_pipe_q[CHOP_DLAY-1];
  assign data_hold_o    = hold_pipe_q[CHOP_DLAY-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      change_s_q  <= '0;
      max_s_q     <= '0;
      default_s_q <= '0;
      hold_s_q    <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      change_s_q  <= change_s_d;
      max_s_q     <= max_s_d;
      default_s_q <= default_s_d;
      hold_s_q    <= hold_s_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Delay lines run in every state so delayed outputs always track chop_o/hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(CHOP_DLAY); i++) begin
        chop_pipe_q[i] <= '0;
        hold_pipe_q[i] <= 1'b0;
      end
    end else begin
      chop_pipe_q[0] <= chop_o;
      hold_pipe_q[0] <= hold;
      for (int i = 1; i < int'(CHOP_DLAY); i++) begin
        chop_pipe_q[i] <= chop_pipe_q[i-1];
        hold_pipe_q[i] <= hold_pipe_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_chop_gen_mc.sv
// Directed bench for chop_gen_mc: waveform, period reload, sync restart, hold, errors, reset.
module tb_chop_gen_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        chop_en = 1'b0;
  logic        sync_i = 1'b0;
  logic [3:0]  chop_default = 4'b0101;
  logic [31:0] change_count = 32'd4;
  logic [31:0] max_count = 32'd10;
  logic [7:0]  hold_len = 8'd3;
  logic [3:0]  chop_o;
  logic [3:0]  chop_dly_o;
  logic        data_hold_o;
  logic        period_start_o;
  logic        cfg_err_o;

  int checks = 0;
  int failures = 0;
  int n;

  chop_gen_mc #(
    .N_CH(4), .CNT_W(32), .HOLD_W(8), .CHOP_DLAY(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chop_en(chop_en), .sync_i(sync_i),
    .chop_default(chop_default), .change_count(change_count), .max_count(max_count),
    .hold_len(hold_len), .chop_o(chop_o), .chop_dly_o(chop_dly_o),
    .data_hold_o(data_hold_o), .period_start_o(period_start_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until the next period_start pulse; bounded so a dead counter cannot hang the run.
  task automatic wait_start(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!period_start_o && cycles < 40);
  endtask

  // Expected waveform for default=0101, change=4, max=10, hold=3.
  function automatic logic [3:0] exp_chop(int c);
    return ((c % 10) < 4) ? 4'b0101 : 4'b1010;
  endfunction

  function automatic logic exp_hold(int c);
    return ((c % 10) < 3) || (((c % 10) >= 4) && ((c % 10) < 7));
  endfunction

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_chop", chop_o, 4'b0101);
    chk("rst_dly", chop_dly_o, 4'b0000);
    chk("rst_hold", data_hold_o, 1'b0);
    chk("rst_pstart", period_start_o, 1'b0);
    chk("rst_err", cfg_err_o, 1'b0);
    #4 reset_n = 1'b1;
    repeat (4) tick();
    chk("idle_dly", chop_dly_o, 4'b0101);

    // Two full periods of the basic waveform.
    chop_en = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      chk("run_chop", chop_o, exp_chop(k));
      chk("run_pstart", period_start_o, (k % 10) == 0);
      chk("run_dly", chop_dly_o, (k < 3) ? 4'b0101 : exp_chop(k - 3));
      chk("run_hold", data_hold_o, (k < 3) ? 1'b0 : exp_hold(k - 3));
      tick();
    end

    // Period change mid-period only applies from the next period.
    repeat (5) tick();
    max_count = 32'd6;
    wait_start(n);
    chk("maxchg_cur", n, 5);
    wait_start(n);
    chk("maxchg_next", n, 6);
    max_count = 32'd10;
    wait_start(n);
    chk("maxchg_back", n, 6);

    // Sync restart at cnt=7.
    repeat (7) tick();
    chk("pre_sync_chop", chop_o, 4'b1010);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    chk("sync_pstart", period_start_o, 1'b1);
    chk("sync_chop", chop_o, 4'b0101);
    tick();
    tick();
    chk("sync_hold_gap", data_hold_o, 1'b0);
    chk("sync_dly_old", chop_dly_o, 4'b1010);
    tick();
    chk("sync_hold_rel", data_hold_o, 1'b1);
    chk("sync_dly_new", chop_dly_o, 4'b0101);

    // Hold longer than each segment gives a continuous flag.
    hold_len = 8'd8;
    wait_start(n);
    chk("hold8_start", n, 7);
    repeat (3) tick();
    for (int k = 0; k < 12; k++) begin
      chk("hold8_cont", data_hold_o, 1'b1);
      tick();
    end

    // Zero hold never asserts the flag.
    hold_len = 8'd0;
    wait_start(n);
    repeat (3) tick();
    for (int k = 0; k < 12; k++) begin
      chk("hold0_off", data_hold_o, 1'b0);
      tick();
    end

    // Invalid config picked up on a wrap reload.
    hold_len = 8'd3;
    chop_en = 1'b0;
    tick();
    chk("idle_err", cfg_err_o, 1'b0);
    chk("idle_pstart", period_start_o, 1'b0);
    chop_en = 1'b1;
    tick();
    chk("restart_pstart", period_start_o, 1'b1);
    repeat (2) tick();
    change_count = 32'd10;
    repeat (7) tick();
    chk("reload_pre_err", cfg_err_o, 1'b0);
    tick();
    chk("reload_err", cfg_err_o, 1'b1);
    chk("reload_err_chop", chop_o, 4'b0101);
    chk("reload_err_pstart", period_start_o, 1'b0);
    chop_en = 1'b0;
    tick();
    chk("err_exit", cfg_err_o, 1'b0);

    // Invalid configs at enable time.
    change_count = 32'd0;
    chop_en = 1'b1;
    tick();
    chk("chg0_err", cfg_err_o, 1'b1);
    chop_default = 4'b0011;
    #1;
    chk("chg0_shadow_chop", chop_o, 4'b0101);
    chop_en = 1'b0;
    tick();
    chk("chg0_exit", cfg_err_o, 1'b0);
    chk("idle_live_chop", chop_o, 4'b0011);
    change_count = 32'd10;
    chop_en = 1'b1;
    tick();
    chk("chgmax_err", cfg_err_o, 1'b1);
    chk("chgmax_chop", chop_o, 4'b0011);
    chop_en = 1'b0;
    tick();
    change_count = 32'd1;
    max_count = 32'd1;
    chop_en = 1'b1;
    tick();
    chk("max1_err", cfg_err_o, 1'b1);
    chop_en = 1'b0;
    tick();
    chk("max1_exit", cfg_err_o, 1'b0);

    // Reset mid-period at cnt=5.
    chop_default = 4'b0101;
    change_count = 32'd4;
    max_count = 32'd10;
    chop_en = 1'b1;
    tick();
    repeat (5) tick();
    chk("pre_rst_chop", chop_o, 4'b1010);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_chop", chop_o, 4'b0101);
    chk("mid_rst_dly", chop_dly_o, 4'b0000);
    chk("mid_rst_hold", data_hold_o, 1'b0);
    chk("mid_rst_pstart", period_start_o, 1'b0);
    chk("mid_rst_err", cfg_err_o, 1'b0);
    chop_en = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    chk("post_rst_dly1", chop_dly_o, 4'b0000);
    chk("post_rst_pstart", period_start_o, 1'b0);
    tick();
    chk("post_rst_dly2", chop_dly_o, 4'b0000);
    tick();
    chk("post_rst_dly3", chop_dly_o, 4'b0101);
    chop_en = 1'b1;
    tick();
    chk("post_rst_restart", period_start_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chop_gen_mc.md
CHOP_GEN_MC -- requirements
Module: chop_gen_mc

Interface
REQ-001 Parameter N_CH, default 4, number of chopper channels (1..32).
REQ-002 Parameter CNT_W, default 32, width of period counter and count inputs.
REQ-003 Parameter HOLD_W, default 8, width of hold-length input.
REQ-004 Parameter CHOP_DLAY, default 3, pipeline delay of delayed outputs (>=1).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 chop_en  in  1  synchronous run enable; 0 = idle.
REQ-008 sync_i  in  1  synchronous period restart request, sampled only while running.
REQ-009 chop_default  in  N_CH  per-channel output level in first half-period.
REQ-010 change_count  in  CNT_W  counter value at which channels invert.
REQ-011 max_count  in  CNT_W  period length in clk cycles.
REQ-012 hold_len  in  HOLD_W  data-hold length after each transition; 0 disables hold.
REQ-013 chop_o  out  N_CH  chopper outputs, undelayed.
REQ-014 chop_dly_o  out  N_CH  chop_o delayed CHOP_DLAY cycles.
REQ-015 data_hold_o  out  1  hold flag delayed CHOP_DLAY cycles.
REQ-016 period_start_o  out  1  one-cycle pulse when counter is 0 in RUN, undelayed.
REQ-017 cfg_err_o  out  1  latched configuration invalid.

Function
REQ-018 FSM states IDLE, RUN, ERR; reset state IDLE.
REQ-019 IDLE: cnt=0, chop_o=chop_default (live), internal hold=0, period_start_o=0, cfg_err_o=0.
REQ-020 IDLE->RUN or IDLE->ERR on first edge with chop_en=1; shadow registers load change_count, max_count, chop_default, hold_len on that edge.
REQ-021 Config valid iff max_count>=2 and 1<=change_count<max_count; invalid -> ERR, valid -> RUN with cnt=0.
REQ-022 RUN: cnt increments by 1 each cycle; at cnt==max_s-1, cnt wraps to 0 next cycle.
REQ-023 Shadow registers reload on every edge where cnt goes to 0 (wrap or sync); live inputs never affect a running period.
REQ-024 Reload with invalid config -> ERR on that edge.
REQ-025 chop_o[i] = default_s[i] while cnt<change_s, = !default_s[i] while cnt>=change_s, all channels switch in the same cycle.
REQ-026 sync_i=1 in RUN forces cnt to 0 next cycle (restart, reload); sync_i coincident with wrap behaves as a single wrap.
REQ-027 period_start_o=1 exactly in cycles with state RUN and cnt==0.
REQ-028 Hold counter loads hold_s on entering cnt==0 or cnt==change_s; internal hold=1 while hold counter !=0; counts down per cycle, so hold covers hold_s cycles starting at the transition cycle.
REQ-029 Transition while hold counter nonzero reloads it (no gap); hold_s>=segment length gives continuous hold.
REQ-030 ERR: chop_o=default_s, hold=0, cfg_err_o=1, cnt=0; stays until chop_en=0.
REQ-031 chop_en=0 in RUN or ERR -> IDLE on next edge, cnt cleared, delay lines keep shifting.
REQ-032 Delay lines shift every cycle in all states; chop_dly_o/data_hold_o equal chop_o/hold from CHOP_DLAY cycles earlier.

Reset
REQ-033 reset_n=0 immediately forces IDLE, cnt=0, hold counter=0, shadows=0, chop_o=chop_default, all delay-line stages=0, period_start_o=0, cfg_err_o=0.
REQ-034 Reset mid-period aborts the period with no further pulses; restart requires chop_en sampled after release.

Verification
REQ-035 N_CH=4, default=4'b0101, change=4, max=10, hold=3, enable -> chop_o 0101 for cnt0-3, 1010 for cnt4-9, period_start every 10 cycles, data_hold_o high at cnt0-2 and 4-6 delayed 3 cycles.
REQ-036 Change max 10->6 mid-period -> current period completes at 10 cycles, next period 6 cycles.
REQ-037 sync_i at cnt=7 -> cnt=0 next cycle, chop_o returns to 0101, hold reloads, period_start pulses.
REQ-038 change=0 or change=max or max=1 -> ERR, cfg_err_o=1, chop_o=default; chop_en=0 -> IDLE, cfg_err_o=0.
REQ-039 hold=8, change=4, max=10 -> data_hold continuous; hold=0 -> data_hold_o never asserted.
REQ-040 reset_n low at cnt=5 -> outputs to reset values immediately, chop_dly_o=0 during CHOP_DLAY cycles after release.
